secded_encoder: RTL



---
 rtl/secded_encoder_if.sv | 40 ++++
 rtl/secded_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/secded_encoder_if.sv
// Handshake and status bundle for the SECDED transmit encoder.
// The slave modport is the encoder's view; the master modport is the producer/consumer side.
interface secded_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [12:0] in_errMask;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_code;
  logic        out_injected;
  logic        count_clr;
  logic [7:0]  enc_count;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_errMask,
    input  out_ready,
    input  count_clr,
    output in_ready,
    output out_valid,
    output out_code,
    output out_injected,
    output enc_count
  );

  modport master (
    output in_valid,
    output in_data,
    output in_errMask,
    output out_ready,
    output count_clr,
    input  in_ready,
    input  out_valid,
    input  out_code,
    input  out_injected,
    input  enc_count
  );
endinterface

// File: rtl/secded_encoder.sv
// Streaming 8-bit to 13-bit SECDED encoder with optional error injection.
// Output stage is a main register plus a one-entry skid buffer.
module secded_encoder (
  input  logic             clock,
  input  logic             reset_L,
  secded_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Bit index equals Hamming position; bit 0 is overall even parity.
  function automatic logic [12:0] encode_word(input logic [7:0] d);
    logic [12:0] c;
    c     = 13'd0;
    c[3]  = d[0];
    c[5]  = d[1];
    c[6]  = d[2];
    c[7]  = d[3];
    c[9]  = d[4];
    c[10] = d[5];
    c[11] = d[6];
    c[12] = d[7];
    c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
    c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
    c[4]  = c[5] ^ c[6] ^ c[7] ^ c[12];
    c[8]  = c[9] ^ c[10] ^ c[11] ^ c[12];
    c[0]  = ^c[12:1];
    return c;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [12:0] main_code_r;
  logic        main_inj_r;
  logic [12:0] skid_code_r;
  logic        skid_inj_r;
  logic [7:0]  count_r;

  logic        ready_s;
  logic        valid_s;
  logic        accept_s;
  logic        handshake_s;
  logic [12:0] new_code_s;
  logic        new_inj_s;
  logic        load_main_in_s;
  logic        load_main_skid_s;
  logic        load_skid_s;

  assign ready_s     = (state_r != ST_FULL);
  assign valid_s     = (state_r != ST_EMPTY);
  assign accept_s    = bus.in_valid & ready_s;
  assign handshake_s = valid_s & bus.out_ready;
  assign new_code_s  = encode_word(bus.in_data) ^ bus.in_errMask;
  assign new_inj_s   = |bus.in_errMask;

  assign bus.in_ready     = ready_s;
  assign bus.out_valid    = valid_s;
  assign bus.out_code     = main_code_r;
  assign bus.out_injected = main_inj_r;
  assign bus.enc_count    = count_r;

  // Skid state register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and register-load decode.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          load_main_in_s = 1'b1;
          state_nxt_s    = ST_ONE;
        end else begin
          state_nxt_s    = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (handshake_s && accept_s) begin
          load_main_in_s = 1'b1;
          state_nxt_s    = ST_ONE;
        end else if (handshake_s) begin
          state_nxt_s    = ST_EMPTY;
        end else if (accept_s) begin
          load_skid_s    = 1'b1;
          state_nxt_s    = ST_FULL;
        end else begin
          state_nxt_s    = ST_ONE;
        end
      end
      ST_FULL: begin
        if (handshake_s) begin
          load_main_skid_s = 1'b1;
          state_nxt_s      = ST_ONE;
        end else begin
          state_nxt_s      = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Main output register; holds steady while stalled.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      main_code_r <= 13'd0;
      main_inj_r  <= 1'b0;
    end else if (load_main_in_s) begin
      main_code_r <= new_code_s;
      main_inj_r  <= new_inj_s;
    end else if (load_main_skid_s) begin
      main_code_r <= skid_code_r;
      main_inj_r  <= skid_inj_r;
    end else begin
      main_code_r <= main_code_r;
      main_inj_r  <= main_inj_r;
    end
  end

  // Skid register catches the word accepted while main is stalled.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      skid_code_r <= 13'd0;
      skid_inj_r  <= 1'b0;
    end else if (load_skid_s) begin
      skid_code_r <= new_code_s;
      skid_inj_r  <= new_inj_s;
    end else begin
      skid_code_r <= skid_code_r;
      skid_inj_r  <= skid_inj_r;
    end
  end

  // Delivered-word counter; clear wins over a simultaneous handshake.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count_r <= 8'd0;
    end else if (bus.count_clr) begin
      count_r <= 8'd0;
    end else if (handshake_s && (count_r != 8'hFF)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule
